// File: rtl/bp_table_ctrl.sv
// Branch prediction table controller.
// Owns a 2^HIST_BITS entry table of 2-bit saturating counters and the global
// branch history register (BHR). After reset it fills every entry with
// INIT_CTR, one entry per cycle, and then serves gshare lookups. It keeps up
// to QDEPTH in-flight predictions, trains the counters as decode resolves
// branches in order, and repairs the BHR on a mispredict.
//
// Ports:
//   clock, resetn        clock and asynchronous active-low reset
//   ready                table initialised (state RUN)
//   lookup_valid/_pc     fetch lookup request and low PC bits
//   lookup_ready         lookup can be accepted (ready and queue not full)
//   predict_valid/_taken registered prediction, one cycle after acceptance
//   resolve_valid/_taken decode resolves the oldest in-flight branch
//   mispredict           combinational: resolve outcome differs from the head
//   resolve_err          sticky: a resolve arrived with nothing in flight
//   mispred_count        saturating mispredict count
module bp_table_ctrl #(
  parameter int         HIST_BITS = 4,
  parameter logic [1:0] INIT_CTR  = 2'b01,
  parameter int         QDEPTH    = 4
) (
  input  logic                 clock,
  input  logic                 resetn,
  output logic                 ready,
  input  logic                 lookup_valid,
  input  logic [HIST_BITS-1:0] lookup_pc,
  output logic                 lookup_ready,
  output logic                 predict_valid,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic                 resolve_taken,
  output logic                 mispredict,
  output logic                 resolve_err,
  output logic [15:0]          mispred_count
);
  localparam int ENTRIES = 1 << HIST_BITS;
  localparam int QW      = $clog2(QDEPTH);

  typedef enum logic {INIT, RUN} state_t;

  typedef struct packed {
    logic [HIST_BITS-1:0] idx;
    logic                 pred;
    logic [HIST_BITS-1:0] bhr;
  } qent_t;

  state_t               state, state_nx;
  logic [HIST_BITS-1:0] init_idx, bhr, idx;
  logic [1:0]           bpt [ENTRIES];
  qent_t                q [QDEPTH];
  qent_t                head;
  logic [QW-1:0]        wr_ptr, rd_ptr;
  logic [QW:0]          q_cnt;
  logic                 q_full, q_empty, res_act, pop, accept, push;
  logic [1:0]           head_ctr, upd_ctr, rd_ctr;

  // ---- FSM ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= INIT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == INIT && (&init_idx)) state_nx = RUN;
  end

  // ---- datapath control ----
  assign ready        = (state == RUN);
  assign q_full       = (q_cnt == (QW+1)'(QDEPTH));
  assign q_empty      = (q_cnt == '0);
  assign lookup_ready = ready && !q_full;
  assign accept       = lookup_valid && lookup_ready;
  assign res_act      = ready && resolve_valid;
  assign pop          = res_act && !q_empty;
  assign head         = q[rd_ptr];
  assign head_ctr     = bpt[head.idx];
  assign mispredict   = pop && (head.pred != resolve_taken);
  // A lookup that coincides with a mispredict is on the wrong path.
  assign push         = accept && !mispredict;
  assign idx          = bhr ^ lookup_pc;

  always_comb begin
    upd_ctr = head_ctr;
    if (resolve_taken) begin
      if (head_ctr != 2'b11) upd_ctr = head_ctr + 2'b01;
    end else begin
      if (head_ctr != 2'b00) upd_ctr = head_ctr - 2'b01;
    end
  end

  // Resolve is ordered before the lookup: forward the counter being written.
  always_comb begin
    rd_ctr = bpt[idx];
    if (pop && head.idx == idx) rd_ctr = upd_ctr;
  end

  // ---- storage (no reset: filled by INIT / written before read) ----
  always_ff @(posedge clock) begin
    if (state == INIT) bpt[init_idx] <= INIT_CTR;
    else if (pop)      bpt[head.idx] <= upd_ctr;
  end

  always_ff @(posedge clock) begin
    if (push) q[wr_ptr] <= '{idx: idx, pred: rd_ctr[1], bhr: bhr};
  end

  // ---- control state ----
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      init_idx      <= '0;
      bhr           <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      q_cnt         <= '0;
      predict_valid <= 1'b0;
      predict_taken <= 1'b0;
      resolve_err   <= 1'b0;
      mispred_count <= '0;
    end else begin
      if (state == INIT) init_idx <= init_idx + 1'b1;

      // BHR repair wins over speculation; on a mispredict push is already 0.
      if (mispredict)  bhr <= {head.bhr[HIST_BITS-2:0], resolve_taken};
      else if (push)   bhr <= {bhr[HIST_BITS-2:0], rd_ctr[1]};

      if (mispredict) begin
        rd_ptr <= wr_ptr;
        q_cnt  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   q_cnt <= q_cnt + 1'b1;
          2'b01:   q_cnt <= q_cnt - 1'b1;
          default: q_cnt <= q_cnt;
        endcase
      end

      predict_valid <= push;
      if (push) predict_taken <= rd_ctr[1];

      if (res_act && q_empty) resolve_err <= 1'b1;
      if (mispredict && mispred_count != 16'hFFFF) mispred_count <= mispred_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_bp_table_ctrl.sv
// Scoreboard bench for bp_table_ctrl (HIST_BITS=4, INIT_CTR=1, QDEPTH=4).
// The stimulus process pushes each expected prediction bit when it issues an
// accepted lookup; the monitor pops and compares whenever predict_valid is seen.
module tb_bp_table_ctrl;
  logic        clock = 1'b0;
  logic        resetn;
  logic        ready, lookup_valid, lookup_ready, predict_valid, predict_taken;
  logic [3:0]  lookup_pc;
  logic        resolve_valid, resolve_taken, mispredict, resolve_err;
  logic [15:0] mispred_count;

  int   total = 0;
  int   bad   = 0;
  logic exp_q [$];
  logic mon_exp;

  bp_table_ctrl #(.HIST_BITS(4), .INIT_CTR(2'b01), .QDEPTH(4)) dut (
    .clock(clock), .resetn(resetn), .ready(ready),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .predict_valid(predict_valid), .predict_taken(predict_taken),
    .resolve_valid(resolve_valid), .resolve_taken(resolve_taken),
    .mispredict(mispredict), .resolve_err(resolve_err), .mispred_count(mispred_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one comparison per presented prediction.
  always @(negedge clock) begin
    if (resetn && predict_valid) begin
      if (exp_q.size() == 0) chk("unexpected_predict", predict_valid, 0);
      else begin
        mon_exp = exp_q.pop_front();
        chk("predict_taken", predict_taken, mon_exp);
      end
    end
  end

  // One cycle: drive, check combinational outputs, queue expected prediction.
  task automatic cyc(input logic lv, input logic [3:0] pc, input logic rv, input logic rt,
                     input logic e_lr, input logic e_mp, input logic e_push, input logic e_pt);
    lookup_valid = lv; lookup_pc = pc; resolve_valid = rv; resolve_taken = rt;
    #1;
    chk("lookup_ready", lookup_ready, e_lr);
    chk("mispredict", mispredict, e_mp);
    if (e_push) exp_q.push_back(e_pt);
    @(posedge clock); #1;
    lookup_valid = 0; resolve_valid = 0; resolve_taken = 0; lookup_pc = 0;
  endtask

  task automatic init_to_ready();
    for (int i = 0; i < 15; i++) cyc(1, 4'(i), 1, 1, 0, 0, 0, 0);
    chk("ready_before_16", ready, 0);
    chk("init_resolve_err", resolve_err, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);
    chk("ready_at_16", ready, 1);
  endtask

  initial begin
    resetn = 0; lookup_valid = 0; lookup_pc = 0; resolve_valid = 0; resolve_taken = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_ready", ready, 0);
    chk("rst_lookup_ready", lookup_ready, 0);
    chk("rst_predict_valid", predict_valid, 0);
    chk("rst_predict_taken", predict_taken, 0);
    chk("rst_resolve_err", resolve_err, 0);
    chk("rst_mispred_count", mispred_count, 0);
    resetn = 1;
    init_to_ready();

    // Init contents: pc=0, BHR=0 -> ctr 1 -> not taken; resolve not taken (ctr0 -> 0).
    cyc(1, 4'd0, 0, 0, 1, 0, 1, 0);
    cyc(0, 4'd0, 1, 0, 1, 0, 0, 0);

    // Training on idx 5, pc chosen so BHR^pc = 5: counter 1->2->3->3.
    cyc(1, 4'd5, 0, 0, 1, 0, 1, 0);
    cyc(0, 4'd0, 1, 1, 1, 1, 0, 0);   // BHR repaired to 0001
    cyc(1, 4'd4, 0, 0, 1, 0, 1, 1);   // BHR -> 0011
    cyc(0, 4'd0, 1, 1, 1, 0, 0, 0);
    cyc(1, 4'd6, 0, 0, 1, 0, 1, 1);   // BHR -> 0111
    cyc(0, 4'd0, 1, 1, 1, 0, 0, 0);
    chk("train_mispred_count", mispred_count, 1);

    // Queue full: four lookups on idx 1 (BHR 0111->1110->1100->1000->0000).
    cyc(1, 4'd6,  0, 0, 1, 0, 1, 0);
    cyc(1, 4'd15, 0, 0, 1, 0, 1, 0);
    cyc(1, 4'd13, 0, 0, 1, 0, 1, 0);
    cyc(1, 4'd9,  0, 0, 1, 0, 1, 0);
    cyc(1, 4'd0,  0, 0, 0, 0, 0, 0);  // full, ignored
    cyc(1, 4'd0,  1, 0, 0, 0, 0, 0);  // pop in same cycle still blocks
    cyc(0, 4'd0,  1, 0, 1, 0, 0, 0);  // drain; ctr1 saturates at 0
    cyc(0, 4'd0,  1, 0, 1, 0, 0, 0);
    cyc(0, 4'd0,  1, 0, 1, 0, 0, 0);

    // Build BHR = 1010 through predictions 1,0,1,0 then resolve them correctly.
    cyc(1, 4'd5, 0, 0, 1, 0, 1, 1);
    cyc(1, 4'd3, 0, 0, 1, 0, 1, 0);
    cyc(1, 4'd7, 0, 0, 1, 0, 1, 1);
    cyc(1, 4'd7, 0, 0, 1, 0, 1, 0);
    cyc(0, 4'd0, 1, 1, 0, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 1, 0, 0, 0);
    cyc(0, 4'd0, 1, 1, 1, 0, 0, 0);
    cyc(0, 4'd0, 1, 0, 1, 0, 0, 0);

    // Mispredict flush: head idx3 pred 0 snapshot 1010, then two younger.
    cyc(1, 4'd9,  0, 0, 1, 0, 1, 0);
    cyc(1, 4'd1,  0, 0, 1, 0, 1, 1);
    cyc(1, 4'd13, 0, 0, 1, 0, 1, 0);
    cyc(1, 4'd0,  1, 1, 1, 1, 0, 0);  // same-cycle lookup discarded
    chk("flush_mispred_count", mispred_count, 2);
    chk("flush_resolve_err_clear", resolve_err, 0);
    cyc(0, 4'd0, 1, 0, 1, 0, 0, 0);   // queue must be empty now
    chk("empty_resolve_err", resolve_err, 1);
    cyc(1, 4'd0, 0, 0, 1, 0, 1, 1);   // BHR 0101 ^ 0 -> idx5 (ctr 3)
    cyc(0, 4'd0, 1, 1, 1, 0, 0, 0);   // BHR stays 1011

    // Same-index resolve and lookup on idx 7.
    cyc(1, 4'd12, 0, 0, 1, 0, 1, 0);  // BHR -> 0110
    cyc(1, 4'd1,  1, 0, 1, 0, 1, 0);  // pop + push, ctr7 forwarded 0
    cyc(0, 4'd0,  1, 0, 1, 0, 0, 0);
    chk("fwd_mispred_count", mispred_count, 2);
    chk("fwd_resolve_err_sticky", resolve_err, 1);

    // Reset mid-run, then mid-INIT.
    resetn = 0; #1;
    chk("rst2_ready", ready, 0);
    chk("rst2_resolve_err", resolve_err, 0);
    chk("rst2_mispred_count", mispred_count, 0);
    chk("rst2_predict_valid", predict_valid, 0);
    @(posedge clock); #1;
    resetn = 1;
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    resetn = 0; #1;
    chk("rst3_ready", ready, 0);
    resetn = 1;
    init_to_ready();
    cyc(1, 4'd5, 0, 0, 1, 0, 1, 0);   // idx5 rewritten to 1 by INIT
    repeat (2) @(posedge clock);
    #1;
    chk("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
